// File: rtl/alarm_bank.sv
// alarm_bank: multi-slot alarm engine with timed ring/snooze rounds, manual snooze and cancel
//   clk, rst_n                 clock, asynchronous active-low reset
//   tick, counter              1 Hz strobe and the current seconds stamp
//   wr_en/wr_idx/wr_stamp/wr_enable/wr_daily   slot write port
//   rd_idx -> rd_stamp/rd_flags                registered read-back, flags = {daily,enable}
//   snooze, cancel             user controls for the alarm in service
//   ring, ring_idx, busy       buzzer drive, slot in service, alarm active (RING or SNOOZE)
module alarm_bank #(
  parameter int NUM_ALARMS   = 4,
  parameter int STAMP_W      = 64,
  parameter int IDX_W        = 2,
  parameter int RING_TICKS   = 5,
  parameter int SNOOZE_TICKS = 10,
  parameter int MAX_ROUNDS   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [STAMP_W-1:0] counter,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [STAMP_W-1:0] wr_stamp,
  input  logic               wr_enable,
  input  logic               wr_daily,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [STAMP_W-1:0] rd_stamp,
  output logic [1:0]         rd_flags,
  input  logic               snooze,
  input  logic               cancel,
  output logic               ring,
  output logic [IDX_W-1:0]   ring_idx,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
  state_t state;
  logic [STAMP_W-1:0] stamps [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] en, daily, pending, match, clr;
  logic [IDX_W-1:0] pick_idx;
  logic [7:0] tcnt;
  logic [3:0] rounds;
  logic wr_ok, rd_ok, abort;
  assign wr_ok = wr_en && (int'(wr_idx) < NUM_ALARMS);
  assign rd_ok = int'(rd_idx) < NUM_ALARMS;
  // a write to the slot being serviced kills the alarm outright
  assign abort = wr_ok && (state != IDLE) && (wr_idx == ring_idx);
  assign clr = (state == IDLE && |pending) ? {{(NUM_ALARMS-1){1'b0}}, 1'b1} << pick_idx : '0;
  always_comb begin
    pick_idx = '0;
    match = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (pending[i]) pick_idx = IDX_W'(i);
      match[i] = tick && en[i] && (stamps[i] == counter);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ALARMS; i++) stamps[i] <= '0;
      en <= '0;
      daily <= '0;
      pending <= '0;
      state <= IDLE;
      tcnt <= '0;
      rounds <= '0;
      ring <= 1'b0;
      busy <= 1'b0;
      ring_idx <= '0;
      rd_stamp <= '0;
      rd_flags <= '0;
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++)
        if (match[i]) begin
          if (daily[i]) stamps[i] <= stamps[i] + STAMP_W'(86400);
          else en[i] <= 1'b0;
        end
      if (wr_ok) begin
        stamps[wr_idx] <= wr_stamp;
        en[wr_idx] <= wr_enable;
        daily[wr_idx] <= wr_daily;
      end
      // a match on the same tick re-arms a slot even as it is taken into service
      pending <= (pending & ~clr) | match;
      rd_stamp <= rd_ok ? stamps[rd_idx] : '0;
      rd_flags <= rd_ok ? {daily[rd_idx], en[rd_idx]} : 2'b00;
      case (state)
        IDLE:
          if (|pending) begin
            state <= RING;
            ring <= 1'b1;
            busy <= 1'b1;
            ring_idx <= pick_idx;
            rounds <= 4'd1;
            tcnt <= '0;
          end
        RING:
          if (abort || cancel) begin
            state <= IDLE;
            ring <= 1'b0;
            busy <= 1'b0;
          end else if (snooze || (tick && tcnt == 8'(RING_TICKS - 1))) begin
            state <= SNOOZE;
            ring <= 1'b0;
            tcnt <= '0;
          end else if (tick) tcnt <= tcnt + 8'd1;
        SNOOZE:
          if (abort || cancel) begin
            state <= IDLE;
            busy <= 1'b0;
          end else if (snooze) tcnt <= '0;
          else if (tick && tcnt == 8'(SNOOZE_TICKS - 1)) begin
            tcnt <= '0;
            if (rounds == 4'(MAX_ROUNDS)) begin
              state <= IDLE;
              busy <= 1'b0;
            end else begin
              state <= RING;
              ring <= 1'b1;
              rounds <= rounds + 4'd1;
            end
          end else if (tick) tcnt <= tcnt + 8'd1;
        default: begin
          state <= IDLE;
          ring <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
